// File: rtl/led_scan_decoder.sv
// ---------------------------------------------------------------------------
// led_scan_decoder
//
// Receive side of an 8-digit multiplexed seven-segment display drive.
// The scanned, active-low enable and segment lines are synchronised and
// checked for stability. The displayed digit codes are then rebuilt. When all
// eight digits have been seen, a whole-frame snapshot is taken. Scan-protocol
// errors are reported on sticky flags.
//
// Optional feature macro: LED_DP_CAPTURE_EN
//   When defined, the decimal point is part of the stability compare, and
//   dp_out[i] holds the captured dp of digit i (1 = lit).
//   When undefined, led_dp is ignored and dp_out is tied to 8'h00.
//
// Parameters
//   STABLE_CYCLES  clocks the synced en/seg(/dp) value must hold before latch
//   CNT_W          stability counter width, must hold STABLE_CYCLES-1
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous, active-high reset
//   led_en[7:0]    digit enables, active-low, bit i = digit i
//   led_ca..led_cg segments a..g, active-low
//   led_dp         decimal point, active-low
//   err_clr        one-cycle pulse, clears the sticky error flags
//   digits[31:0]   live code per digit, digit i at [4i+3:4i]
//   frame_digits   snapshot of digits taken when all 8 digits were latched
//   frame_done     one-cycle pulse after frame_digits updates
//   err_multi_en   sticky: two or more enables low at once
//   err_seg        sticky: an unrecognised segment pattern was latched
//   dp_out[7:0]    per-digit captured decimal point, 1 = lit
// ---------------------------------------------------------------------------
module led_scan_decoder #(
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  led_en,
    input  logic        led_ca,
    input  logic        led_cb,
    input  logic        led_cc,
    input  logic        led_cd,
    input  logic        led_ce,
    input  logic        led_cf,
    input  logic        led_cg,
    input  logic        led_dp,
    input  logic        err_clr,
    output logic [31:0] digits,
    output logic [31:0] frame_digits,
    output logic        frame_done,
    output logic        err_multi_en,
    output logic        err_seg,
    output logic [7:0]  dp_out
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TRACK   = 2'd1,
        LATCHED = 2'd2
    } state_t;

    // Segment decode: active-low {g,f,e,d,c,b,a} -> digit code.
    // Unknown patterns map to 4'hE, which is never a legal code.
    function automatic logic [3:0] decode_seg(input logic [6:0] seg);
        case (seg)
            7'h40:   decode_seg = 4'h0;
            7'h79:   decode_seg = 4'h1;
            7'h24:   decode_seg = 4'h2;
            7'h30:   decode_seg = 4'h3;
            7'h19:   decode_seg = 4'h4;
            7'h12:   decode_seg = 4'h5;
            7'h02:   decode_seg = 4'h6;
            7'h78:   decode_seg = 4'h7;
            7'h00:   decode_seg = 4'h8;
            7'h18:   decode_seg = 4'h9;
            7'h7F:   decode_seg = 4'hF;
            default: decode_seg = 4'hE;
        endcase
    endfunction

    // ---------------------------------------------------------------
    // Two-flop synchronisers. Reset values equal an idle, blanked bus,
    // so no change is seen when reset is released.
    // ---------------------------------------------------------------
    logic [6:0] seg_pin;
    logic [7:0] en_m, s_en;
    logic [6:0] seg_m, s_seg;

    assign seg_pin = {led_cg, led_cf, led_ce, led_cd, led_cc, led_cb, led_ca};

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_m  <= 8'hFF;
            s_en  <= 8'hFF;
            seg_m <= 7'h7F;
            s_seg <= 7'h7F;
        end else begin
            en_m  <= led_en;
            s_en  <= en_m;
            seg_m <= seg_pin;
            s_seg <= seg_m;
        end
    end

`ifdef LED_DP_CAPTURE_EN
    localparam int VW = 16;
    logic dp_m, s_dp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_m <= 1'b1;
            s_dp <= 1'b1;
        end else begin
            dp_m <= led_dp;
            s_dp <= dp_m;
        end
    end
`else
    localparam int VW = 15;
    logic unused_dp;
    assign unused_dp = led_dp;
`endif

    // ---------------------------------------------------------------
    // Change detect and stability counter
    // ---------------------------------------------------------------
    logic [VW-1:0]    cur_vec, prev_vec;
    logic             changed;
    logic [CNT_W-1:0] stab_cnt;

`ifdef LED_DP_CAPTURE_EN
    assign cur_vec = {s_en, s_seg, s_dp};
`else
    assign cur_vec = {s_en, s_seg};
`endif

    assign changed = (cur_vec != prev_vec);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_vec <= {VW{1'b1}};
            stab_cnt <= '0;
        end else begin
            prev_vec <= cur_vec;
            if (changed)
                stab_cnt <= '0;
            else if (stab_cnt != CNT_MAX)
                stab_cnt <= stab_cnt + 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Enable classification
    // ---------------------------------------------------------------
    logic [7:0] en_low;
    logic       one_hot, multi;
    logic [2:0] idx;

    assign en_low  = ~s_en;
    assign one_hot = (en_low != 8'h00) && ((en_low & (en_low - 8'd1)) == 8'h00);
    assign multi   = (en_low != 8'h00) && !one_hot;

    // NOTE: every variable written in always_comb gets a default first,
    // otherwise paths that skip an assignment infer a latch.
    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!s_en[i])
                idx = 3'(i);
        end
    end

    // ---------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ---------------------------------------------------------------
    state_t state, state_nxt;
    logic   latch_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (one_hot)
                    state_nxt = TRACK;
            end
            TRACK: begin
                if (!one_hot)
                    state_nxt = IDLE;
                else if (!changed && stab_cnt == CNT_MAX)
                    state_nxt = LATCHED;
            end
            LATCHED: begin
                if (changed)
                    state_nxt = one_hot ? TRACK : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The count is stale in a cycle that shows a change, so the latch waits
    // for a quiet cycle.
    always_comb begin
        latch_en = (state == TRACK) && one_hot && !changed && (stab_cnt == CNT_MAX);
    end

    // ---------------------------------------------------------------
    // Digit store, frame tracking
    // ---------------------------------------------------------------
    logic [3:0]  code;
    logic        seg_bad;
    logic [31:0] digits_nxt;
    logic [7:0]  seen, seen_nxt;

    assign code    = decode_seg(s_seg);
    assign seg_bad = (code == 4'hE);

    always_comb begin
        digits_nxt = digits;
        digits_nxt[idx*4 +: 4] = code;
        seen_nxt = seen | (8'd1 << idx);
    end

    // NOTE: the digit store is a handful of flops with a defined power-up
    // value (all blank), so it is reset; large RAM arrays would not be.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits       <= 32'hFFFF_FFFF;
            frame_digits <= 32'hFFFF_FFFF;
            frame_done   <= 1'b0;
            seen         <= 8'h00;
        end else begin
            frame_done <= 1'b0;
            // The snapshot cycle leaves seen full, and the cycle after
            // (frame_done high) empties it for the next frame.
            if (frame_done)
                seen <= 8'h00;
            if (latch_en) begin
                digits <= digits_nxt;
                seen   <= seen_nxt;
                if (seen_nxt == 8'hFF) begin
                    frame_digits <= digits_nxt;
                    frame_done   <= 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Sticky errors: a set condition wins over a coincident clear
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_multi_en <= 1'b0;
            err_seg      <= 1'b0;
        end else begin
            err_multi_en <= multi | (err_multi_en & ~err_clr);
            err_seg      <= (latch_en & seg_bad) | (err_seg & ~err_clr);
        end
    end

    // ---------------------------------------------------------------
    // Decimal point capture
    // ---------------------------------------------------------------
`ifdef LED_DP_CAPTURE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dp_out <= 8'h00;
        else if (latch_en)
            dp_out[idx] <= ~s_dp;
    end
`else
    assign dp_out = 8'h00;
`endif

endmodule

// File: tb/tb_led_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_led_scan_decoder
//
// Scoreboard bench for led_scan_decoder (STABLE_CYCLES = 4). The stimulus
// pushes the expected digits value for each update it causes, and the
// expected snapshot for each frame it completes. A monitor on the falling
// edge pops and compares whenever digits changes or frame_done pulses. An
// event with nothing queued is reported as an error. Sticky flags and dp_out
// are compared directly at fixed points.
// ---------------------------------------------------------------------------
module tb_led_scan_decoder;

    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  led_en;
    logic        led_ca, led_cb, led_cc, led_cd, led_ce, led_cf, led_cg, led_dp;
    logic        err_clr;
    logic [31:0] digits, frame_digits;
    logic        frame_done, err_multi_en, err_seg;
    logic [7:0]  dp_out;

    led_scan_decoder #(
        .STABLE_CYCLES (STABLE),
        .CNT_W         (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .led_en       (led_en),
        .led_ca       (led_ca),
        .led_cb       (led_cb),
        .led_cc       (led_cc),
        .led_cd       (led_cd),
        .led_ce       (led_ce),
        .led_cf       (led_cf),
        .led_cg       (led_cg),
        .led_dp       (led_dp),
        .err_clr      (err_clr),
        .digits       (digits),
        .frame_digits (frame_digits),
        .frame_done   (frame_done),
        .err_multi_en (err_multi_en),
        .err_seg      (err_seg),
        .dp_out       (dp_out)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          frame_cnt = 0;
    logic [31:0] exp_digits_q[$];
    logic [31:0] exp_frame_q[$];
    logic [31:0] last_digits = 32'hFFFF_FFFF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: the DUT "presents an output" when digits changes or frame_done pulses.
    always @(negedge clk) begin
        if (digits !== last_digits) begin
            if (exp_digits_q.size() == 0)
                check("digits_unexpected_change", digits, last_digits);
            else
                check("digits_update", digits, exp_digits_q.pop_front());
            last_digits = digits;
        end
        if (frame_done === 1'b1) begin
            frame_cnt++;
            if (exp_frame_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL frame_done_unexpected: got frame_done=1 frame_digits=%h expected no pulse",
                         frame_digits);
            end else begin
                check("frame_digits", frame_digits, exp_frame_q.pop_front());
            end
        end
    end

    // Drive the pins and hold them for n clocks; always entered and left at posedge+1.
    task automatic drive(input logic [7:0] en, input logic [6:0] seg, input logic dp, input int n);
        led_en = en;
        {led_cg, led_cf, led_ce, led_cd, led_cc, led_cb, led_ca} = seg;
        led_dp = dp;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
    endtask

    logic [6:0]  seg_tab  [8] = '{7'h00, 7'h79, 7'h02, 7'h40, 7'h40, 7'h24, 7'h40, 7'h79};
    logic [3:0]  code_tab [8] = '{4'h8, 4'h1, 4'h6, 4'h0, 4'h0, 4'h2, 4'h0, 4'h1};
    logic [31:0] exp_d;

    initial begin
        rst     = 1'b1;
        err_clr = 1'b0;
        led_en  = 8'hFF;
        {led_cg, led_cf, led_ce, led_cd, led_cc, led_cb, led_ca} = 7'h7F;
        led_dp  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_digits", digits, 32'hFFFF_FFFF);
        check("reset_dp_out", {24'h0, dp_out}, 32'h0);
        rst = 1'b0;

        // 1: reset in the middle of a scan
        exp_digits_q.push_back(32'hFFFF_FFF3);
        drive(8'hFE, 7'h30, 1'b1, 20);
        drive(8'hFF, 7'h7F, 1'b1, 5);
        drive(8'hFD, 7'h79, 1'b1, 3);
        exp_digits_q.push_back(32'hFFFF_FFFF);
        rst = 1'b1;
        drive(8'hFF, 7'h7F, 1'b1, 2);
        check("rst_digits", digits, 32'hFFFF_FFFF);
        check("rst_frame_digits", frame_digits, 32'hFFFF_FFFF);
        check("rst_frame_done", {31'h0, frame_done}, 32'h0);
        check("rst_errs", {30'h0, err_multi_en, err_seg}, 32'h0);
        rst = 1'b0;
        drive(8'hFF, 7'h7F, 1'b1, 5);

        // 2: full frame of digits 8,1,6,0,0,2,0,1
        exp_d = 32'hFFFF_FFFF;
        for (int i = 0; i < 8; i++) begin
            exp_d[i*4 +: 4] = code_tab[i];
            exp_digits_q.push_back(exp_d);
            if (i == 7)
                exp_frame_q.push_back(exp_d);
            drive(~(8'd1 << i), seg_tab[i], 1'b1, 20);
            drive(8'hFF, 7'h7F, 1'b1, 5);
        end
        check("frame_digits_value", digits, 32'h1020_0618);
        check("frame_count", frame_cnt, 1);

        // 3: digit 1 shown for too short a time, so nothing latches
        drive(8'hFD, 7'h30, 1'b1, 3);
        drive(8'hFF, 7'h7F, 1'b1, 10);
        check("short_hold_digits", digits, 32'h1020_0618);

        // 4: multiple enables low, clear, then a set that coincides with a clear
        drive(8'hFC, 7'h7F, 1'b1, 10);
        check("multi_en_set", {31'h0, err_multi_en}, 32'h1);
        check("multi_en_digits", digits, 32'h1020_0618);
        drive(8'hFF, 7'h7F, 1'b1, 5);
        pulse_clr();
        check("multi_en_cleared", {31'h0, err_multi_en}, 32'h0);
        drive(8'hFC, 7'h7F, 1'b1, 5);
        pulse_clr();
        check("multi_en_set_wins", {31'h0, err_multi_en}, 32'h1);
        drive(8'hFF, 7'h7F, 1'b1, 5);
        pulse_clr();
        check("multi_en_cleared2", {31'h0, err_multi_en}, 32'h0);

        // 5: unrecognised segment pattern on digit 0
        exp_digits_q.push_back(32'h1020_061E);
        drive(8'hFE, 7'h2A, 1'b1, 10);
        check("bad_seg_flag", {31'h0, err_seg}, 32'h1);
        check("bad_seg_multi_clear", {31'h0, err_multi_en}, 32'h0);
        drive(8'hFF, 7'h7F, 1'b1, 5);

        // 6: decimal point lit while digit 3 latches (digit code unchanged)
        drive(8'hF7, 7'h40, 1'b0, 10);
`ifdef LED_DP_CAPTURE_EN
        check("dp_out_capture", {24'h0, dp_out}, 32'h0000_0008);
`else
        check("dp_out_tied", {24'h0, dp_out}, 32'h0);
`endif
        drive(8'hFF, 7'h7F, 1'b1, 10);

        check("digits_queue_empty", exp_digits_q.size(), 0);
        check("frame_queue_empty", exp_frame_q.size(), 0);
        check("final_frame_count", frame_cnt, 1);
        check("final_digits", digits, 32'h1020_061E);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
